img_preproc_ctrl: RTL and testbench

Frame-level sequencer for the image preprocessing pipeline (interface convert → decimation → difference/BRAM → packetiser). It resets the pipeline before each capture run and schedules reference versus difference frames. It gates DDR storage for a programmed number of frames, watches the pipeline's error flags, and reports completion and sticky status to software.

---
 rtl/img_preproc_pkg.sv | 11 +
 rtl/img_preproc_ctrl_ref_phase_cnt.sv | 19 +
 rtl/img_preproc_ctrl.sv | 129 ++++++++++++
 tb/tb_img_preproc_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_preproc_pkg.sv
// img_preproc_pkg: shared encodings for the image preprocessing frame sequencer
package img_preproc_pkg;
   localparam logic [1:0] FT_BYPASS = 2'b00;
   localparam logic [1:0] FT_REF = 2'b01;
   localparam logic [1:0] FT_DIFF = 2'b10;
   localparam int ERR_OVF = 0;
   localparam int ERR_DATA = 1;
   localparam int ERR_TLAST = 2;
   localparam int ERR_TO = 3;
   typedef enum logic [2:0] {IDLE, INIT, ARMED, RUN, DRAIN, ERR} state_t;
endpackage

// File: rtl/img_preproc_ctrl_ref_phase_cnt.sv
// ref_phase_cnt: modulo-period frame phase counter with next frame-type decode
module ref_phase_cnt
   import img_preproc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         clr,
   input  logic         adv,
   input  logic         diff,
   input  logic [W-1:0] period,
   output logic [1:0]   nxt_type
);
   logic [W-1:0] ph, ph_nxt;
   always_comb ph_nxt = ({1'b0, ph} + (W+1)'(1) >= {1'b0, period}) ? '0 : ph + W'(1);
   assign nxt_type = !diff ? FT_BYPASS : ph_nxt == '0 ? FT_REF : FT_DIFF;
   always_ff @(posedge aclk) ph <= (areset || clr) ? '0 : adv ? ph_nxt : ph;
endmodule

// File: rtl/img_preproc_ctrl.sv
// img_preproc_ctrl: frame-level run sequencer for the image preprocessing pipeline
module img_preproc_ctrl
   import img_preproc_pkg::*;
#(
   parameter int REF_PERIOD_W = 8,
   parameter int FRAME_CNT_W  = 16,
   parameter int INIT_LEN     = 4,
   parameter int DRAIN_TO_W   = 24
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    cfg_diff_en,
   input  logic [REF_PERIOD_W-1:0] cfg_ref_period,
   input  logic [FRAME_CNT_W-1:0]  cfg_num_frames,
   input  logic                    sof,
   input  logic                    frame_store,
   input  logic                    fifo_overflow,
   input  logic                    unexpected_data,
   input  logic                    unexpected_tlast,
   output logic                    init_txn,
   output logic                    diff_en,
   output logic                    wr2ddr_en,
   output logic [1:0]              frame_type,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              err_flags,
   output logic [FRAME_CNT_W-1:0]  frame_cnt,
   output logic [FRAME_CNT_W-1:0]  stored_cnt
);
   localparam int IW = $clog2(INIT_LEN + 1);
   state_t state, nxt;
   logic cfg_diff;
   logic [REF_PERIOD_W-1:0] cfg_period;
   logic [FRAME_CNT_W-1:0] cfg_num, fc_inc, st_nxt;
   logic [IW-1:0] icnt;
   logic [DRAIN_TO_W-1:0] to_cnt;
   logic go, err_any, init_end, to_exp, last, cnt_sof, cnt_st, drained;
   logic init_d, diff_d, wr_d, busy_d, done_d;
   logic [1:0] nxt_type;
   logic [3:0] err_new;
   assign go = state == IDLE && start;
   assign err_any = fifo_overflow | unexpected_data | unexpected_tlast;
   assign init_end = icnt == IW'(INIT_LEN - 1);
   assign to_exp = &to_cnt;
   assign fc_inc = &frame_cnt ? frame_cnt : frame_cnt + FRAME_CNT_W'(1);
   assign cnt_st = frame_store && (state == RUN || state == DRAIN);
   assign st_nxt = (cnt_st && !(&stored_cnt)) ? stored_cnt + FRAME_CNT_W'(1) : stored_cnt;
   assign last = cfg_num != '0 && fc_inc == cfg_num;
   assign cnt_sof = sof && !err_any && (state == RUN || (state == ARMED && !stop));
   assign drained = st_nxt == frame_cnt;
   ref_phase_cnt #(.W(REF_PERIOD_W)) u_phase (
      .aclk(aclk),
      .areset(areset),
      .clr(go),
      .adv(cnt_sof),
      .diff(cfg_diff),
      .period(cfg_period),
      .nxt_type(nxt_type)
   );
   always_ff @(posedge aclk) state <= areset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = start ? INIT : IDLE;
         INIT:  nxt = err_any ? ERR : init_end ? ARMED : INIT;
         ARMED: nxt = err_any ? ERR : stop ? IDLE : sof ? (last ? DRAIN : RUN) : ARMED;
         RUN:   nxt = err_any ? ERR : (stop || (sof && last)) ? DRAIN : RUN;
         DRAIN: nxt = (err_any || to_exp) ? ERR : drained ? IDLE : DRAIN;
         ERR:   nxt = init_end ? IDLE : ERR;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      init_d = nxt == INIT || nxt == ERR;
      wr_d = nxt == ARMED || nxt == RUN;
      diff_d = cfg_diff && (nxt == ARMED || nxt == RUN || nxt == DRAIN);
      busy_d = nxt != IDLE;
      done_d = state == DRAIN && nxt == IDLE;
      err_new = '0;
      err_new[ERR_OVF] = fifo_overflow;
      err_new[ERR_DATA] = unexpected_data;
      err_new[ERR_TLAST] = unexpected_tlast;
      err_new[ERR_TO] = state == DRAIN && to_exp && !err_any;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         cfg_diff <= 1'b0;
         cfg_period <= '0;
         cfg_num <= '0;
         icnt <= '0;
         to_cnt <= DRAIN_TO_W'(1);
         init_txn <= 1'b0;
         diff_en <= 1'b0;
         wr2ddr_en <= 1'b0;
         frame_type <= FT_BYPASS;
         busy <= 1'b0;
         done <= 1'b0;
         err_flags <= '0;
         frame_cnt <= '0;
         stored_cnt <= '0;
      end else begin
         icnt <= (nxt == state && (state == INIT || state == ERR)) ? icnt + IW'(1) : '0;
         to_cnt <= state == DRAIN ? to_cnt + DRAIN_TO_W'(1) : DRAIN_TO_W'(1);
         init_txn <= init_d;
         diff_en <= diff_d;
         wr2ddr_en <= wr_d;
         busy <= busy_d;
         done <= done_d;
         if (go) begin
            cfg_diff <= cfg_diff_en;
            cfg_period <= cfg_ref_period;
            cfg_num <= cfg_num_frames;
            frame_type <= cfg_diff_en ? FT_REF : FT_BYPASS;
            frame_cnt <= '0;
            stored_cnt <= '0;
            err_flags <= '0;
         end else begin
            if (cnt_sof) begin
               frame_cnt <= fc_inc;
               frame_type <= nxt_type;
            end
            stored_cnt <= st_nxt;
            if (state != ERR && nxt == ERR) err_flags <= err_flags | err_new;
         end
      end
   end
endmodule

// File: tb/tb_img_preproc_ctrl.sv
// tb_img_preproc_ctrl: table-driven, randomized and hand-sequenced checks of the frame sequencer
module tb_img_preproc_ctrl;
   localparam int FW = 16;
   localparam int PW = 8;
   logic aclk = 1'b0, areset = 1'b1, start = 1'b0, stop = 1'b0, cfg_diff_en = 1'b0;
   logic [PW-1:0] cfg_ref_period = '0;
   logic [FW-1:0] cfg_num_frames = '0;
   logic sof = 1'b0, frame_store = 1'b0;
   logic fifo_overflow = 1'b0, unexpected_data = 1'b0, unexpected_tlast = 1'b0;
   logic init_txn, diff_en, wr2ddr_en, busy, done;
   logic [1:0] frame_type;
   logic [3:0] err_flags;
   logic [FW-1:0] frame_cnt, stored_cnt;
   int n_chk = 0, n_err = 0;
   typedef struct {
      bit diff;
      int period;
      int num;
      int stop_at;
      int exp_n;
   } run_t;
   run_t tbl[6];
   always #5 aclk = ~aclk;
   img_preproc_ctrl #(
      .REF_PERIOD_W(PW),
      .FRAME_CNT_W(FW),
      .INIT_LEN(4),
      .DRAIN_TO_W(4)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .start(start),
      .stop(stop),
      .cfg_diff_en(cfg_diff_en),
      .cfg_ref_period(cfg_ref_period),
      .cfg_num_frames(cfg_num_frames),
      .sof(sof),
      .frame_store(frame_store),
      .fifo_overflow(fifo_overflow),
      .unexpected_data(unexpected_data),
      .unexpected_tlast(unexpected_tlast),
      .init_txn(init_txn),
      .diff_en(diff_en),
      .wr2ddr_en(wr2ddr_en),
      .frame_type(frame_type),
      .busy(busy),
      .done(done),
      .err_flags(err_flags),
      .frame_cnt(frame_cnt),
      .stored_cnt(stored_cnt)
   );
   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int ft_ref(input bit diff, input int period, input int k);
      return !diff ? 0 : (period <= 1 || k % period == 0) ? 1 : 2;
   endfunction
   task automatic arm(input bit diff, input int period, input int num, input bit init_noise);
      cfg_diff_en = diff;
      cfg_ref_period = period[PW-1:0];
      cfg_num_frames = num[FW-1:0];
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("init_rise", init_txn, 1);
      chk("busy_start", busy, 1);
      chk("err_clr", err_flags, 0);
      chk("fcnt_clr", frame_cnt, 0);
      chk("wr_init", wr2ddr_en, 0);
      for (int i = 0; i < 3; i++) begin
         stop = init_noise && i == 0;
         sof = init_noise && i == 1;
         cyc();
         stop = 1'b0;
         sof = 1'b0;
         chk("init_hold", init_txn, 1);
      end
      cyc();
      chk("init_len", init_txn, 0);
      chk("armed_wr", wr2ddr_en, 1);
      chk("armed_diff", diff_en, diff);
      chk("init_sof_ignored", frame_cnt, 0);
   endtask
   task automatic do_run(input run_t r, input bit extra);
      int st = 0;
      arm(r.diff, r.period, r.num, 1'($urandom_range(0, 1)));
      for (int k = 0; k < r.exp_n; k++) begin
         chk("frame_type", frame_type, ft_ref(r.diff, r.period, k));
         repeat ($urandom_range(0, 2)) begin
            cyc();
            chk("ft_stable", frame_type, ft_ref(r.diff, r.period, k));
         end
         sof = 1'b1;
         stop = r.stop_at == k + 1;
         cyc();
         sof = 1'b0;
         stop = 1'b0;
         chk("frame_cnt", frame_cnt, k + 1);
         chk("wr2ddr", wr2ddr_en, k + 1 < r.exp_n);
         if (k > 0) begin
            frame_store = 1'b1;
            cyc();
            frame_store = 1'b0;
            st++;
            chk("stored_cnt_run", stored_cnt, st);
            chk("no_early_done", done, 0);
         end
      end
      if (extra) begin
         sof = 1'b1;
         cyc();
         sof = 1'b0;
         chk("drain_sof_ignored", frame_cnt, r.exp_n);
      end
      chk("done_low", done, 0);
      chk("busy_drain", busy, 1);
      frame_store = 1'b1;
      cyc();
      frame_store = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      chk("stored_cnt", stored_cnt, r.exp_n);
      chk("frame_cnt_end", frame_cnt, r.exp_n);
      cyc();
      chk("done_one_cycle", done, 0);
      chk("cnt_kept_idle", frame_cnt, r.exp_n);
   endtask
   task automatic sof_pulse();
      sof = 1'b1;
      cyc();
      sof = 1'b0;
   endtask
   initial begin
      run_t r;
      tbl[0] = '{diff: 1, period: 3, num: 6, stop_at: 0, exp_n: 6};
      tbl[1] = '{diff: 1, period: 0, num: 4, stop_at: 0, exp_n: 4};
      tbl[2] = '{diff: 1, period: 1, num: 3, stop_at: 0, exp_n: 3};
      tbl[3] = '{diff: 0, period: 3, num: 5, stop_at: 0, exp_n: 5};
      tbl[4] = '{diff: 1, period: 2, num: 0, stop_at: 5, exp_n: 5};
      tbl[5] = '{diff: 1, period: 4, num: 1, stop_at: 0, exp_n: 1};
      repeat (3) cyc();
      chk("rst_init", init_txn, 0);
      chk("rst_diff", diff_en, 0);
      chk("rst_wr", wr2ddr_en, 0);
      chk("rst_ft", frame_type, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_flags, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_scnt", stored_cnt, 0);
      areset = 1'b0;
      cyc();
      foreach (tbl[i]) do_run(tbl[i], i == 4);
      repeat (20) begin
         int n = $urandom_range(1, 7);
         bit use_stop = 1'($urandom_range(0, 1));
         r = '{diff: 1'($urandom_range(0, 1)), period: $urandom_range(0, 5),
               num: use_stop ? 0 : n, stop_at: use_stop ? n : 0, exp_n: n};
         do_run(r, 1'($urandom_range(0, 1)));
      end
      arm(1, 3, 0, 0);
      sof_pulse();
      sof_pulse();
      fifo_overflow = 1'b1;
      cyc();
      fifo_overflow = 1'b0;
      chk("ovf_flag", err_flags, 1);
      chk("ovf_init", init_txn, 1);
      chk("ovf_wr", wr2ddr_en, 0);
      chk("ovf_diff", diff_en, 0);
      chk("ovf_busy", busy, 1);
      repeat (3) begin
         cyc();
         chk("ovf_init_hold", init_txn, 1);
      end
      cyc();
      chk("ovf_init_end", init_txn, 0);
      chk("ovf_idle", busy, 0);
      chk("ovf_no_done", done, 0);
      chk("ovf_sticky", err_flags, 1);
      arm(0, 0, 0, 0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("armed_stop_idle", busy, 0);
      chk("armed_stop_no_done", done, 0);
      chk("armed_stop_wr", wr2ddr_en, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      unexpected_tlast = 1'b1;
      unexpected_data = 1'b1;
      cyc();
      unexpected_tlast = 1'b0;
      unexpected_data = 1'b0;
      chk("init_err_flags", err_flags, 6);
      chk("init_err_txn", init_txn, 1);
      repeat (4) cyc();
      chk("init_err_idle", busy, 0);
      arm(1, 2, 2, 0);
      sof_pulse();
      sof_pulse();
      chk("to_drain_wr", wr2ddr_en, 0);
      repeat (14) cyc();
      chk("to_early", err_flags, 0);
      cyc();
      chk("to_flag", err_flags, 8);
      chk("to_init", init_txn, 1);
      chk("to_busy", busy, 1);
      repeat (4) cyc();
      chk("to_idle", busy, 0);
      chk("to_no_done", done, 0);
      arm(1, 3, 0, 0);
      sof_pulse();
      sof_pulse();
      areset = 1'b1;
      cyc();
      chk("arst_init", init_txn, 0);
      chk("arst_diff", diff_en, 0);
      chk("arst_wr", wr2ddr_en, 0);
      chk("arst_ft", frame_type, 0);
      chk("arst_busy", busy, 0);
      chk("arst_fcnt", frame_cnt, 0);
      chk("arst_err", err_flags, 0);
      areset = 1'b0;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
